// File: rtl/pll_rst_supervisor.sv
// -----------------------------------------------------------------------------
// pll_rst_supervisor
//
// Reset/lock supervisor for the PLL clock wrapper. It pulses the PLL reset,
// waits for lock with a timeout and a bounded number of retries, and requires
// lock to stay high for a qualification window. Only then does it release the
// downstream logic reset. In RUN, a filtered lock loss re-initialises the PLL
// automatically.
//
// Ports (all logic is on the rising edge of clkin1):
//   clkin1        in   board clock (50 MHz, also the PLL reference)
//   sys_rst       in   synchronous active-high reset
//   pll_lock      in   PLL lock flag, asynchronous to clkin1
//   force_relock  in   single-cycle request for a full PLL re-initialisation
//   pll_rst       out  active-high PLL reset
//   user_rst      out  active-high reset for the PLL-clocked logic
//   locked_ok     out  high while in RUN
//   fail          out  high while in FAIL (sticky)
//   retry_cnt     out  timeout retries used in the current bring-up
//   lock_loss_cnt out  lock-loss events since sys_rst, saturating at 255
// -----------------------------------------------------------------------------
module pll_rst_supervisor #(
  parameter int unsigned RST_CYCLES          = 10,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOSS_FILTER_CYCLES  = 4,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       clkin1,
  input  logic       sys_rst,
  input  logic       pll_lock,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       user_rst,
  output logic       locked_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > LOSS_FILTER_CYCLES) ?
                                    LOCK_STABLE_CYCLES : LOSS_FILTER_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_FILTER_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  // Explicit encodings keep the legacy state numbering visible in waveforms.
  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          sync1_q, lock_s_q;
  logic          pll_rst_q, user_rst_q, locked_ok_q, fail_q;

  // Two-flop synchroniser; the FSM never looks at pll_lock directly.
  always_ff @(posedge clkin1) begin
    if (sys_rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    if (force_relock) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        S_RUN: begin
          // cnt tracks the current run of consecutive low lock samples.
          if (lock_s_q) begin
            cnt_d = '0;
          end else if (cnt_q == LOSS_LAST) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            if (loss_q != '1) begin
              loss_d = loss_q + 8'd1;
            end
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register rather than one cycle later.
  always_ff @(posedge clkin1) begin
    if (sys_rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      user_rst_q  <= 1'b1;
      locked_ok_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == S_RESET_PLL);
      user_rst_q  <= (state_d != S_RUN);
      locked_ok_q <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign user_rst      = user_rst_q;
  assign locked_ok     = locked_ok_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: doc/pll_rst_supervisor.md
Name: pll_rst_supervisor

Overview:
- Companion controller for the PLL clock wrapper. It drives the PLL's `pll_rst` input and watches the PLL's `pll_lock` output, which is the other end of that reset/lock interface.
- Sequences power-up reset, waits for lock with a timeout and retries, and qualifies lock stability.
- Holds a downstream active-high logic reset (`user_rst`) until lock is stable. Detects lock loss and re-initialises the PLL automatically.
- Runs on the 50 MHz board clock that also feeds the PLL input.

Parameters:
- RST_CYCLES, 10, cycles `pll_rst` is held high per reset attempt (200 ns at 50 MHz); minimum 1.
- LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before a retry (1 ms).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before release.
- LOSS_FILTER_CYCLES, 4, consecutive synchronised-lock-low cycles in RUN that count as lock loss.
- MAX_RETRIES, 7, timeout retries allowed before FAIL; range 0..15.

Ports:
- clkin1  input  1  board clock, 50 MHz; all logic is on its rising edge.
- sys_rst  input  1  synchronous active-high reset.
- pll_lock  input  1  PLL lock flag, asynchronous to clkin1.
- force_relock  input  1  single-cycle pulse that requests a full PLL re-initialisation.
- pll_rst  output  1  reset to the PLL, active-high.
- user_rst  output  1  reset for the PLL-clocked logic, active-high.
- locked_ok  output  1  high while in RUN.
- fail  output  1  high while in FAIL.
- retry_cnt  output  4  timeout retries used in the current bring-up.
- lock_loss_cnt  output  8  lock-loss events since sys_rst; saturates at 255.

Behaviour:
- Clock and reset: one clock (clkin1). Reset is synchronous and active-high (sys_rst). All outputs are registered.
- Values while sys_rst is high:
  - state = RESET_PLL, and the single shared cycle counter `cnt` = 0.
  - pll_rst = 1, user_rst = 1.
  - locked_ok = 0, fail = 0.
  - retry_cnt = 0, lock_loss_cnt = 0.
  - Both synchroniser flops = 0.
- Lock synchroniser: pll_lock passes through a 2-flop synchroniser to give `lock_s`. Input-to-`lock_s` latency is 2 cycles. The FSM uses only `lock_s`.
- Counter width: `cnt` is sized by $clog2 of the largest cycle parameter. It clears on every state transition.
- RESET_PLL:
  - Outputs: pll_rst = 1, user_rst = 1, locked_ok = 0.
  - `cnt` counts; at `cnt == RST_CYCLES-1` go to WAIT_LOCK.
  - Result: pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - Outputs: pll_rst = 0, user_rst = 1.
  - If lock_s = 1, go to STABLE. Lock takes priority over timeout in the same cycle.
  - Otherwise, at `cnt == LOCK_TIMEOUT_CYCLES-1`:
    - if retry_cnt == MAX_RETRIES, go to FAIL;
    - else increment retry_cnt and go to RESET_PLL.
- STABLE:
  - Outputs: pll_rst = 0, user_rst = 1.
  - lock_s = 0 → return to WAIT_LOCK with a fresh timeout. retry_cnt is unchanged.
  - `cnt == LOCK_STABLE_CYCLES-1` with lock_s = 1 → go to RUN.
- RUN:
  - Outputs: pll_rst = 0, user_rst = 0, locked_ok = 1. These take effect on the first cycle the state register reads RUN.
  - Entering RUN clears retry_cnt.
  - `cnt` counts consecutive lock_s = 0 cycles and clears whenever lock_s = 1.
  - At LOSS_FILTER_CYCLES consecutive low cycles:
    - increment lock_loss_cnt (saturating at 255);
    - go to RESET_PLL.
  - user_rst and pll_rst rise together on the next cycle.
  - A low glitch shorter than LOSS_FILTER_CYCLES is ignored.
- FAIL:
  - Outputs: pll_rst = 0, user_rst = 1, fail = 1.
  - The state is sticky; it exits only via sys_rst or force_relock.
- force_relock:
  - In any state, go to RESET_PLL with cnt = 0 and retry_cnt = 0. lock_loss_cnt is unchanged.
  - Asserted during RESET_PLL, it restarts the RST_CYCLES count.
  - It has priority over every other transition in the same cycle. sys_rst has priority over force_relock.
- Glitch-free outputs: user_rst never deasserts while pll_rst = 1. pll_rst and user_rst are glitch-free register outputs.

Test Plan (bench parameters: RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, LOSS_FILTER_CYCLES=3, MAX_RETRIES=2):
1. Release sys_rst; raise pll_lock 5 cycles after pll_rst falls and hold it -> pll_rst high exactly 4 cycles; user_rst falls 2+8 cycles after pll_lock rises; locked_ok=1; retry_cnt=0.
2. Hold pll_lock=0 -> three pll_rst pulses of 4 cycles, each separated by 20 low cycles; retry_cnt goes 0,1,2; then fail=1, user_rst=1 and pll_rst stays 0 indefinitely.
3. In FAIL, pulse force_relock, then provide lock -> fail=0, retry_cnt=0, and normal release as in scenario 1.
4. In RUN, drop pll_lock for 2 cycles -> no change. Drop it for 3 cycles -> lock_loss_cnt=1; pll_rst and user_rst rise on the same cycle; pll_rst high 4 cycles.
5. In STABLE, drop lock_s after 5 of 8 cycles -> back to WAIT_LOCK, retry_cnt unchanged; re-lock requires a full 8 fresh stable cycles.
6. Assert force_relock in RUN on the same cycle as the 3rd low lock cycle -> RESET_PLL entered once, lock_loss_cnt unchanged. Assert sys_rst together with force_relock -> all counters 0.
